ex_muldiv_unit: RTL



---
 rtl/ex_md_pkg.sv | 38 +++
 rtl/md_div_step.sv | 23 ++
 rtl/ex_muldiv_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_md_pkg.sv
// ex_md_pkg: shared encodings and helpers for the RV32M multiply/divide unit.
package ex_md_pkg;

   // md_op_i values, identical to the RV32M funct3 field
   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // Divide/remainder ops occupy the upper half of the encoding space
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // rs1 is interpreted as two's complement
   function automatic logic is_signed_a(input logic [2:0] op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is interpreted as two's complement (MULHSU keeps rs2 unsigned)
   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == MD_MUL) || (op == MD_MULH) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/md_div_step.sv
// md_div_step: one restoring-divide iteration on unsigned magnitudes.
module md_div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic            bit_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_bit_o
);

   logic [XLEN:0]   shifted_c;
   logic [XLEN+1:0] diff_c;

   // Shift in the next dividend bit, trial-subtract, restore on borrow
   always_comb begin
      shifted_c = {rem_i, bit_i};
      diff_c    = {1'b0, shifted_c} - {2'b00, divisor_i};
      q_bit_o   = ~diff_c[XLEN+1];
      rem_o     = q_bit_o ? diff_c[XLEN-1:0] : shifted_c[XLEN-1:0];
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit sitting beside EX.
// Optional build macro EX_MD_EARLY_OUT_EN: trivial operands (divisor 0 or 1,
// multiply operand 0) bypass iteration and finish two cycles after start.
module ex_muldiv_unit
   import ex_md_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MUL_BITS = 1,
   parameter int unsigned CNT_W    = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      md_op_i,
   input  logic [XLEN-1:0] r1_data_i,
   input  logic [XLEN-1:0] r2_data_i,
   input  logic            w_enable_i,
   input  logic [4:0]      w_addr_i,
   input  logic            flush_i,
   output logic            stall_req_o,
   output logic            valid_o,
   output logic            w_enable_o,
   output logic [4:0]      w_addr_o,
   output logic [XLEN-1:0] w_data_o
);

   localparam int unsigned MUL_ITERS = XLEN / MUL_BITS;
   localparam int unsigned DIV_ITERS = XLEN;
   localparam int unsigned SUM_W     = XLEN + MUL_BITS;

   logic [2:0]      state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]      op_q;
   logic [XLEN-1:0] a_abs_q, b_abs_q;
   logic            neg_a_q, neg_b_q, div0_q, w_en_q;
   logic [4:0]      w_addr_q;
   logic [XLEN-1:0] acc_hi_q, acc_lo_q;

   logic            a_neg_c, b_neg_c, trivial_c, issue_c;
   logic [XLEN-1:0] a_abs_c, b_abs_c;
   logic [MUL_BITS-1:0] digit_c;
   logic [SUM_W-1:0]    mul_sum_c;
   logic [2*XLEN+MUL_BITS-1:0] mul_cat_c;
   logic [XLEN-1:0] div_rem_c;
   logic            div_qbit_c;
   logic [2*XLEN-1:0] prod_c, prod_s_c;
   logic [XLEN-1:0] quot_c, remd_c, result_c;

   // Operand decode: magnitudes, signs and early-out detection
   always_comb begin
      a_neg_c = is_signed_a(md_op_i) & r1_data_i[XLEN-1];
      b_neg_c = is_signed_b(md_op_i) & r2_data_i[XLEN-1];
      a_abs_c = a_neg_c ? -r1_data_i : r1_data_i;
      b_abs_c = b_neg_c ? -r2_data_i : r2_data_i;
      issue_c = start_i & ~flush_i;
`ifdef EX_MD_EARLY_OUT_EN
      if (is_div(md_op_i)) begin
         trivial_c = (r2_data_i == '0) || (r2_data_i == XLEN'(1));
      end else begin
         trivial_c = (r1_data_i == '0) || (r2_data_i == '0);
      end
`else
      trivial_c = 1'b0;
`endif
   end

   // Multiply step: add multiplicand times low digit, shift accumulator right
   always_comb begin
      digit_c   = acc_lo_q[MUL_BITS-1:0];
      mul_sum_c = SUM_W'(acc_hi_q) + SUM_W'(a_abs_q) * SUM_W'(digit_c);
      mul_cat_c = {mul_sum_c, acc_lo_q};
   end

   md_div_step #(
      .XLEN(XLEN)
   ) u_div_step (
      .rem_i    (acc_hi_q),
      .bit_i    (acc_lo_q[XLEN-1]),
      .divisor_i(b_abs_q),
      .rem_o    (div_rem_c),
      .q_bit_o  (div_qbit_c)
   );

   // Sign correction and result selection used in FIX
   always_comb begin
      prod_c   = {acc_hi_q, acc_lo_q};
      prod_s_c = (neg_a_q ^ neg_b_q) ? -prod_c : prod_c;
      if (div0_q) begin
         quot_c = '1;
         remd_c = neg_a_q ? -a_abs_q : a_abs_q;
      end else begin
         quot_c = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
         remd_c = neg_a_q ? -acc_hi_q : acc_hi_q;
      end
      case (op_q)
         MD_MUL:                      result_c = prod_s_c[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result_c = prod_s_c[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:             result_c = quot_c;
         default:                     result_c = remd_c;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and pipeline stall request
   always_comb begin
      state_d     = state_q;
      stall_req_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall_req_o = issue_c;
            if (issue_c) begin
               if (trivial_c)              state_d = ST_FIX;
               else if (is_div(md_op_i))   state_d = ST_DIV;
               else                        state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            stall_req_o = 1'b1;
            if (cnt_q == CNT_W'(MUL_ITERS - 1)) state_d = ST_FIX;
         end
         ST_DIV: begin
            stall_req_o = 1'b1;
            if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            stall_req_o = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush_i) state_d = ST_IDLE;
   end

   // Operand latch, iteration datapath and registered write-back outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         op_q       <= MD_MUL;
         a_abs_q    <= '0;
         b_abs_q    <= '0;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         div0_q     <= 1'b0;
         w_en_q     <= 1'b0;
         w_addr_q   <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         valid_o    <= 1'b0;
         w_enable_o <= 1'b0;
         w_addr_o   <= '0;
         w_data_o   <= '0;
      end else begin
         valid_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (issue_c) begin
                  cnt_q    <= '0;
                  op_q     <= md_op_i;
                  a_abs_q  <= a_abs_c;
                  b_abs_q  <= b_abs_c;
                  neg_a_q  <= a_neg_c;
                  neg_b_q  <= b_neg_c;
                  div0_q   <= is_div(md_op_i) && (r2_data_i == '0);
                  w_en_q   <= w_enable_i && (w_addr_i != 5'd0);
                  w_addr_q <= (w_enable_i && (w_addr_i != 5'd0)) ? w_addr_i : 5'd0;
                  acc_hi_q <= '0;
                  // Divide shifts the dividend out of acc_lo; multiply shifts rs2 out
                  if (is_div(md_op_i)) acc_lo_q <= a_abs_c;
                  else if (trivial_c)  acc_lo_q <= '0;
                  else                 acc_lo_q <= b_abs_c;
               end
            end
            ST_MUL: begin
               acc_hi_q <= mul_cat_c[2*XLEN+MUL_BITS-1 -: XLEN];
               acc_lo_q <= mul_cat_c[XLEN+MUL_BITS-1 -: XLEN];
               cnt_q    <= cnt_q + CNT_W'(1);
            end
            ST_DIV: begin
               acc_hi_q <= div_rem_c;
               acc_lo_q <= {acc_lo_q[XLEN-2:0], div_qbit_c};
               cnt_q    <= cnt_q + CNT_W'(1);
            end
            ST_FIX: begin
               if (!flush_i) begin
                  valid_o    <= 1'b1;
                  w_enable_o <= w_en_q;
                  w_addr_o   <= w_addr_q;
                  w_data_o   <= result_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
